// File: rtl/sseg_scan_arbiter.sv
// Two-requester arbiter and digit scanner for a 4-digit multiplexed 7-segment display.
// Ownership changes and value snapshots happen only on frame boundaries, so a frame never mixes two values.
module sseg_scan_arbiter #(
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLANK_CYC   = 500,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] num0,
    input  logic [15:0] num1,
    input  logic        lz_en,
    output logic [1:0]  gnt,
    output logic [3:0]  an,
    output logic [3:0]  bcd,
    output logic        blank,
    output logic        frame_start
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int SW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW  = $clog2(HOLD_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t        state, state_n;
    logic          run;
    logic [SW-1:0] slot_cnt, slot_n;
    logic [1:0]    d, d_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          rr, rr_n;
    logic [15:0]   snap, snap_n;
    logic          boundary;
    logic [3:0]    nib;
    logic          lzb;

    // The first edge after reset starts frame 0 without advancing the counters.
    always_comb begin
        slot_n   = slot_cnt;
        d_n      = d;
        boundary = 1'b0;
        if (!run) begin
            boundary = 1'b1;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_n   = '0;
            d_n      = d + 2'd1;
            boundary = (d == 2'd3);
        end else begin
            slot_n = slot_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        rr_n    = rr;
        snap_n  = snap;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (req[rr])       state_n = rr ? OWN1 : OWN0;
                    else if (req[~rr]) state_n = rr ? OWN0 : OWN1;
                end
                OWN0: begin
                    if (!req[0])                          state_n = req[1] ? OWN1 : IDLE;
                    else if (hold_cnt >= HOLD_MAX && req[1]) state_n = OWN1;
                end
                OWN1: begin
                    if (!req[1])                          state_n = req[0] ? OWN0 : IDLE;
                    else if (hold_cnt >= HOLD_MAX && req[0]) state_n = OWN0;
                end
                default: state_n = IDLE;
            endcase
            // rr points at the side that did not just win
            if (state_n != IDLE && state_n != state) begin
                hold_n = HW'(1);
                rr_n   = (state_n == OWN0);
            end else if (state_n != IDLE && hold_cnt < HOLD_MAX) begin
                hold_n = hold_cnt + 1'b1;
            end
            if (state_n == OWN0)      snap_n = num0;
            else if (state_n == OWN1) snap_n = num1;
        end
    end

    // Display terms use next-cycle values so the registered outputs line up with d/slot_cnt.
    always_comb begin
        nib = 4'(snap_n >> {d_n, 2'b00});
        lzb = lz_en && (d_n != 2'd0) && ((snap_n >> {d_n, 2'b00}) == 16'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            slot_cnt    <= '0;
            d           <= 2'd0;
            state       <= IDLE;
            hold_cnt    <= '0;
            rr          <= 1'b0;
            snap        <= 16'd0;
            gnt         <= 2'b00;
            an          <= 4'b1111;
            bcd         <= 4'd0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            slot_cnt    <= slot_n;
            d           <= d_n;
            state       <= state_n;
            hold_cnt    <= hold_n;
            rr          <= rr_n;
            snap        <= snap_n;
            gnt         <= {state_n == OWN1, state_n == OWN0};
            frame_start <= boundary;
            bcd         <= nib;
            if (int'(slot_n) < BLANK_CYC) begin
                an    <= 4'b1111;
                blank <= 1'b1;
            end else begin
                an    <= ~(4'b0001 << d_n);
                blank <= lzb;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// Bench for sseg_scan_arbiter: frame-level reference model checked every cycle,
// plus directed literal checks of scan order, leading zeros, hold/round-robin, coherence and async reset.
module tb_sseg_scan_arbiter;

    localparam int DIV   = 10;
    localparam int BLK   = 2;
    localparam int HOLD  = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] num0 = 16'h0000;
    logic [15:0] num1 = 16'h0000;
    logic        lz_en = 1'b0;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        blank;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    sseg_scan_arbiter #(
        .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(BLK), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .num0(num0), .num1(num1), .lz_en(lz_en),
        .gnt(gnt), .an(an), .bcd(bcd), .blank(blank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle count since release, frame-level arbitration.
    bit          mrun = 0;
    int          mc = 0;
    int          mown = -1;
    int          mrr = 0;
    int          mhold = 0;
    logic [15:0] msnap = 16'h0;
    logic [3:0]  e_an = 4'hF;
    logic [3:0]  e_bcd = 4'h0;
    logic        e_blank = 1'b1;
    logic [1:0]  e_gnt = 2'b00;
    logic        e_fs = 1'b0;

    task automatic mreset();
        mrun = 0; mc = 0; mown = -1; mrr = 0; mhold = 0; msnap = 16'h0;
        e_an = 4'hF; e_bcd = 4'h0; e_blank = 1'b1; e_gnt = 2'b00; e_fs = 1'b0;
    endtask

    task automatic mstep();
        bit bnd;
        int nxt, slot, dd;
        logic [15:0] sh;
        if (!mrun) begin
            mrun = 1; mc = 0; bnd = 1;
        end else begin
            mc++; bnd = (mc % FRAME == 0);
        end
        slot = mc % DIV;
        dd   = (mc / DIV) % 4;
        if (bnd) begin
            nxt = mown;
            if (mown < 0) begin
                if (req[mrr])          nxt = mrr;
                else if (req[1 - mrr]) nxt = 1 - mrr;
            end else if (!req[mown]) begin
                nxt = req[1 - mown] ? 1 - mown : -1;
            end else if (mhold >= HOLD && req[1 - mown]) begin
                nxt = 1 - mown;
            end
            if (nxt >= 0 && nxt != mown) begin
                mrr = 1 - nxt; mhold = 1;
            end else if (nxt >= 0 && mhold < HOLD) begin
                mhold++;
            end
            mown = nxt;
            if (mown == 0) msnap = num0;
            else if (mown == 1) msnap = num1;
        end
        e_fs  = bnd;
        e_gnt = (mown == 0) ? 2'b01 : (mown == 1) ? 2'b10 : 2'b00;
        sh    = msnap >> (4 * dd);
        e_bcd = sh[3:0];
        if (slot < BLK) begin
            e_an = 4'hF; e_blank = 1'b1;
        end else begin
            e_an    = ~(4'(1) << dd);
            e_blank = lz_en && (dd > 0) && (sh == 16'h0);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) mreset();
        else mstep();
    end

    initial forever begin
        @(negedge clk);
        chk("gnt", gnt, e_gnt);
        chk("an", an, e_an);
        chk("blank", blank, e_blank);
        chk("frame_start", frame_start, e_fs);
        if (e_an != 4'hF) chk("bcd", bcd, e_bcd);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 3 * FRAME);
        chk("wait_frame", frame_start, 1'b1);
    endtask

    // At a frame's first cycle: visit slot cycle 5 of each digit.
    task automatic chk_digit(input string name, input logic [3:0] ea, input logic [3:0] eb, input logic ebl);
        chk({name, "_an"}, an, ea);
        chk({name, "_blank"}, blank, ebl);
        if (!ebl) chk({name, "_bcd"}, bcd, eb);
    endtask

    logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] bcd_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [1:0] gnt_tab [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};

    initial begin
        // reset state
        step(3);
        chk("rst_an", an, 4'hF);
        chk("rst_blank", blank, 1'b1);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_bcd", bcd, 4'h0);
        chk("rst_fs", frame_start, 1'b0);
        rst = 1'b1;
        step();
        chk("first_fs", frame_start, 1'b1);
        chk("first_gnt", gnt, 2'b00);

        // scan order
        req = 2'b01; num0 = 16'h1234;
        wait_frame();
        chk("scan_gnt", gnt, 2'b01);
        chk("scan_blank_gap", an, 4'hF);
        step(5);
        for (int k = 0; k < 4; k++) begin
            chk_digit("scan", an_tab[k], bcd_tab[k], 1'b0);
            step(DIV);
        end

        // leading zeros
        num0 = 16'h0050; lz_en = 1'b1;
        wait_frame();
        step(5);
        chk_digit("lz_d0", 4'hE, 4'h0, 1'b0); step(DIV);
        chk_digit("lz_d1", 4'hD, 4'h5, 1'b0); step(DIV);
        chk_digit("lz_d2", 4'hB, 4'h0, 1'b1); step(DIV);
        chk_digit("lz_d3", 4'h7, 4'h0, 1'b1);
        num0 = 16'h0000;
        wait_frame();
        step(5);
        chk_digit("z_d0", 4'hE, 4'h0, 1'b0); step(DIV);
        chk_digit("z_d1", 4'hD, 4'h0, 1'b1);

        // coherence
        lz_en = 1'b0; num0 = 16'h1111;
        wait_frame();
        step(DIV + 5);
        chk("coh_d1", bcd, 4'h1);
        num0 = 16'h2222;
        step(DIV); chk("coh_d2", bcd, 4'h1);
        step(DIV); chk("coh_d3", bcd, 4'h1);
        wait_frame();
        step(5); chk("coh_next", bcd, 4'h2);

        // drop all requests: idle keeps last value
        req = 2'b00;
        wait_frame();
        chk("idle_gnt", gnt, 2'b00);
        step(5);
        chk("idle_bcd", bcd, 4'h2);
        chk("idle_an", an, 4'hE);

        // async reset mid-slot
        req = 2'b01;
        wait_frame();
        step(13);
        chk("pre_rst_gnt", gnt, 2'b01);
        #1 rst = 1'b0;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_gnt", gnt, 2'b00);
        req = 2'b11;
        step(2);
        rst = 1'b1;

        // hold and round-robin from reset
        for (int f = 0; f < 5; f++) begin
            wait_frame();
            chk("rr_gnt", gnt, gnt_tab[f]);
        end
        step(20);
        req = 2'b10;
        step(5);
        chk("drop_mid_gnt", gnt, 2'b01);
        wait_frame();
        chk("drop_gnt", gnt, 2'b10);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(59) == 0) req = 2'($urandom);
            if ($urandom_range(149) == 0) num0 = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
            if ($urandom_range(149) == 0) num1 = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
            if ($urandom_range(299) == 0) lz_en = ~lz_en;
            if ($urandom_range(999) == 0) begin
                #1 rst = 1'b0;
                step(2);
                rst = 1'b1;
            end
        end

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
